// File: rtl/cordic.sv
// CORDIC rotator, rotation mode, fully pipelined.
// Rotates (Xin, Yin) by a full-circle phase and scales the result by the CORDIC
// gain K ~= 1.64676. One sample is accepted every clock. Results appear 32
// rising edges after sampling: one input stage plus 31 micro-rotation stages.
module cordic (
   input  logic               clock,
   input  logic               reset_n,
   input  logic        [31:0] angle,
   input  logic signed [31:0] Xin,
   input  logic signed [31:0] Yin,
   output logic signed [32:0] Xout,
   output logic signed [32:0] Yout
);

   // Number of micro-rotation stages following the input register.
   localparam int NUM_STAGES = 31;

   // Angle of each micro-rotation, atan(2^-i), in units of 2^-32 full circle.
   function automatic logic [31:0] atan_lut(input int idx);
      case (idx)
         0:       atan_lut = 32'h2000_0000;
         1:       atan_lut = 32'h12E4_051E;
         2:       atan_lut = 32'h09FB_385B;
         3:       atan_lut = 32'h0511_11D4;
         4:       atan_lut = 32'h028B_0D43;
         5:       atan_lut = 32'h0145_D7E1;
         6:       atan_lut = 32'h00A2_F61E;
         7:       atan_lut = 32'h0051_7C55;
         8:       atan_lut = 32'h0028_BE53;
         9:       atan_lut = 32'h0014_5F2F;
         10:      atan_lut = 32'h000A_2F98;
         11:      atan_lut = 32'h0005_17CC;
         12:      atan_lut = 32'h0002_8BE6;
         13:      atan_lut = 32'h0001_45F3;
         14:      atan_lut = 32'h0000_A2FA;
         15:      atan_lut = 32'h0000_517D;
         16:      atan_lut = 32'h0000_28BE;
         17:      atan_lut = 32'h0000_145F;
         18:      atan_lut = 32'h0000_0A30;
         19:      atan_lut = 32'h0000_0518;
         20:      atan_lut = 32'h0000_028C;
         21:      atan_lut = 32'h0000_0146;
         22:      atan_lut = 32'h0000_00A3;
         23:      atan_lut = 32'h0000_0051;
         24:      atan_lut = 32'h0000_0029;
         25:      atan_lut = 32'h0000_0014;
         26:      atan_lut = 32'h0000_000A;
         27:      atan_lut = 32'h0000_0005;
         28:      atan_lut = 32'h0000_0003;
         29:      atan_lut = 32'h0000_0001;
         30:      atan_lut = 32'h0000_0001;
         default: atan_lut = 32'h0000_0000;
      endcase
   endfunction

   // Sign-extended inputs; 33 bits leave headroom for the K gain.
   logic signed [32:0] xin_ext_s;
   logic signed [32:0] yin_ext_s;
   // Quadrant-folded vector and residual angle feeding the input register.
   logic signed [32:0] pre_x_s;
   logic signed [32:0] pre_y_s;
   logic        [31:0] pre_z_s;

   // Pipeline state: index 0 is the input register, index i+1 is stage i output.
   // The residual angle of the last stage is never needed, so z stops at 30.
   logic signed [32:0] x_r [0:NUM_STAGES];
   logic signed [32:0] y_r [0:NUM_STAGES];
   logic        [31:0] z_r [0:NUM_STAGES-1];

   assign xin_ext_s = {Xin[31], Xin};
   assign yin_ext_s = {Yin[31], Yin};

   // Fold the second and third quadrants by +/-90 deg so the residual angle
   // lies within the +/-99.9 deg convergence range of the micro-rotations.
   always_comb begin
      pre_x_s = xin_ext_s;
      pre_y_s = yin_ext_s;
      pre_z_s = angle;
      case (angle[31:30])
         2'b01: begin
            pre_x_s = -yin_ext_s;
            pre_y_s = xin_ext_s;
            pre_z_s = angle - 32'h4000_0000;
         end
         2'b10: begin
            pre_x_s = yin_ext_s;
            pre_y_s = -xin_ext_s;
            pre_z_s = angle + 32'h4000_0000;
         end
         default: begin
            pre_x_s = xin_ext_s;
            pre_y_s = yin_ext_s;
            pre_z_s = angle;
         end
      endcase
   end

   // Input register: capture the quadrant-folded sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_r[0] <= 33'sd0;
         y_r[0] <= 33'sd0;
         z_r[0] <= 32'd0;
      end else begin
         x_r[0] <= pre_x_s;
         y_r[0] <= pre_y_s;
         z_r[0] <= pre_z_s;
      end
   end

   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      localparam logic [31:0] ATAN_C = atan_lut(i);

      // Stage i: rotate x/y by atan(2^-i) toward the residual angle.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            x_r[i+1] <= 33'sd0;
            y_r[i+1] <= 33'sd0;
         end else if (z_r[i][31]) begin
            x_r[i+1] <= x_r[i] + (y_r[i] >>> i);
            y_r[i+1] <= y_r[i] - (x_r[i] >>> i);
         end else begin
            x_r[i+1] <= x_r[i] - (y_r[i] >>> i);
            y_r[i+1] <= y_r[i] + (x_r[i] >>> i);
         end
      end

      if (i < NUM_STAGES - 1) begin : g_z
         // Stage i: remove the angle just rotated from the residual.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               z_r[i+1] <= 32'd0;
            end else if (z_r[i][31]) begin
               z_r[i+1] <= z_r[i] + ATAN_C;
            end else begin
               z_r[i+1] <= z_r[i] - ATAN_C;
            end
         end
      end
   end

   assign Xout = x_r[NUM_STAGES];
   assign Yout = y_r[NUM_STAGES];

endmodule

// File: tb/tb_cordic.sv
// Directed testbench for the pipelined CORDIC rotator.
module tb_cordic;

   localparam longint TOL     = 64'sd2048;
   localparam longint FULL    = 64'sd2147483648;
   localparam int     LAT_M1  = 31;
   localparam int     MAX_VEC = 360;

   logic               clock   = 1'b0;
   logic               reset_n = 1'b1;
   logic        [31:0] angle   = 32'd0;
   logic signed [31:0] Xin     = 32'sd0;
   logic signed [31:0] Yin     = 32'sd0;
   logic signed [32:0] Xout;
   logic signed [32:0] Yout;

   logic        [31:0] ang_v [0:MAX_VEC-1];
   logic signed [31:0] xin_v [0:MAX_VEC-1];
   logic signed [31:0] yin_v [0:MAX_VEC-1];
   longint             ex_v  [0:MAX_VEC-1];
   longint             ey_v  [0:MAX_VEC-1];

   int n_cmp = 0;
   int n_bad = 0;

   cordic dut (
      .clock   (clock),
      .reset_n (reset_n),
      .angle   (angle),
      .Xin     (Xin),
      .Yin     (Yin),
      .Xout    (Xout),
      .Yout    (Yout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
      longint d;
      n_cmp++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic set_vec(input int idx, input logic [31:0] a, input logic [31:0] xi,
                          input logic [31:0] yi, input longint ex, input longint ey);
      ang_v[idx] = a;
      xin_v[idx] = xi;
      yin_v[idx] = yi;
      ex_v[idx]  = ex;
      ey_v[idx]  = ey;
   endtask

   // Stream n_vec vectors, one per clock, checking each result 32 edges after
   // it was sampled; optionally require zero output while the pipe refills.
   task automatic run_vectors(input int n_vec, input bit zero_lead);
      for (int n = 0; n < n_vec + LAT_M1; n++) begin
         if (n < n_vec) begin
            angle = ang_v[n];
            Xin   = xin_v[n];
            Yin   = yin_v[n];
         end else begin
            angle = 32'd0;
            Xin   = 32'sd0;
            Yin   = 32'sd0;
         end
         @(posedge clock);
         #1;
         if (n >= LAT_M1) begin
            chk($sformatf("x[%0d] ang=%h", n - LAT_M1, ang_v[n - LAT_M1]), Xout, ex_v[n - LAT_M1], TOL);
            chk($sformatf("y[%0d] ang=%h", n - LAT_M1, ang_v[n - LAT_M1]), Yout, ey_v[n - LAT_M1], TOL);
         end else if (zero_lead) begin
            chk($sformatf("lead_x@%0d", n), Xout, 64'sd0, 64'sd0);
            chk($sformatf("lead_y@%0d", n), Yout, 64'sd0, 64'sd0);
         end
      end
   endtask

   task automatic load_sweep();
      for (int i = 0; i < MAX_VEC; i++) begin
         longint a;
         real    r;
         a = (64'sd4294967296 * i) / 360;
         r = 6.283185307179586 * real'(a) / 4294967296.0;
         set_vec(i, a[31:0], 32'h4DBA_76D4, 32'h0000_0000,
                 longint'($cos(r) * 2147483648.0), longint'($sin(r) * 2147483648.0));
      end
   endtask

   initial begin
      // Reset holds outputs at zero even with live inputs clocking in.
      #2;
      reset_n = 1'b0;
      angle   = 32'h1555_5555;
      Xin     = 32'sh4DBA_76D4;
      Yin     = 32'sh1234_5678;
      #1;
      chk("rst_x", Xout, 64'sd0, 64'sd0);
      chk("rst_y", Yout, 64'sd0, 64'sd0);
      repeat (3) @(posedge clock);
      #1;
      chk("rst_hold_x", Xout, 64'sd0, 64'sd0);
      chk("rst_hold_y", Yout, 64'sd0, 64'sd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Directed vectors; expected values are cos/sin * 2^31 worked by hand.
      set_vec(0,  32'h0000_0000, 32'h4DBA_76D4, 32'h0000_0000,  FULL,           64'sd0);
      set_vec(1,  32'h4000_0000, 32'h4DBA_76D4, 32'h0000_0000,  64'sd0,         FULL);
      set_vec(2,  32'h8000_0000, 32'h4DBA_76D4, 32'h0000_0000, -FULL,           64'sd0);
      set_vec(3,  32'hC000_0000, 32'h4DBA_76D4, 32'h0000_0000,  64'sd0,        -FULL);
      set_vec(4,  32'h1555_5555, 32'h4DBA_76D4, 32'h0000_0000,  64'sd1859775393, 64'sd1073741824);
      set_vec(5,  32'h2AAA_AAAB, 32'h4DBA_76D4, 32'h0000_0000,  64'sd1073741824, 64'sd1859775393);
      set_vec(6,  32'h2000_0000, 32'h4DBA_76D4, 32'h0000_0000,  64'sd1518500250, 64'sd1518500250);
      set_vec(7,  32'hA000_0000, 32'h4DBA_76D4, 32'h0000_0000, -64'sd1518500250, -64'sd1518500250);
      set_vec(8,  32'h5555_5555, 32'h4DBA_76D4, 32'h0000_0000, -64'sd1073741824, 64'sd1859775393);
      set_vec(9,  32'hFFFF_FFFF, 32'h4DBA_76D4, 32'h0000_0000,  FULL,           -64'sd3);
      set_vec(10, 32'h0000_0000, 32'h0000_0000, 32'h4DBA_76D4,  64'sd0,         FULL);
      set_vec(11, 32'h4000_0000, 32'hB245_892C, 32'h0000_0000,  64'sd0,        -FULL);
      set_vec(12, 32'hE000_0000, 32'h4DBA_76D4, 32'h4DBA_76D4,  64'sd3037000500, 64'sd0);
      run_vectors(13, 1'b1);

      // Full-rate sweep, one degree per clock.
      load_sweep();
      run_vectors(MAX_VEC, 1'b0);

      // Reset in the middle of a sweep discards all in-flight samples.
      for (int n = 0; n < 50; n++) begin
         angle = ang_v[n];
         Xin   = xin_v[n];
         Yin   = yin_v[n];
         @(posedge clock);
      end
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_x", Xout, 64'sd0, 64'sd0);
      chk("mid_rst_y", Yout, 64'sd0, 64'sd0);
      @(posedge clock);
      #1;
      chk("mid_hold_x", Xout, 64'sd0, 64'sd0);
      chk("mid_hold_y", Yout, 64'sd0, 64'sd0);
      @(negedge clock);
      reset_n = 1'b1;
      run_vectors(MAX_VEC, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
